// File: rtl/intdiv_otfconv.sv
// SD2 quotient digits (MSB first) -> two's-complement word via on-the-fly Q/QM conversion, optional -1 correction.
// Result valid the cycle after the N-th digit; digits stall only while a finished word is held unaccepted.
module intdiv_otfconv #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_digit,
  input  logic         in_adj,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_q,
  output logic         out_ovf
);

  localparam int W  = N + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {ACC, HOLD} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    q, qm, q_nxt, qm_nxt, r;
  logic [CW-1:0]   cnt;
  logic            acc, last;

  assign in_ready  = (state == ACC) || out_ready;
  assign out_valid = (state == HOLD);
  assign acc       = in_valid && in_ready;
  assign last      = acc && (cnt == CW'(N - 1));

  // qm always tracks q-1, so a -1 digit never needs a borrow chain
  always_comb begin
    q_nxt  = {q[W-2:0], 1'b1};
    qm_nxt = {q[W-2:0], 1'b0};
    case (in_digit)
      2'b11: begin
        q_nxt  = {qm[W-2:0], 1'b1};
        qm_nxt = {qm[W-2:0], 1'b0};
      end
      2'b00: begin
        q_nxt  = {q[W-2:0], 1'b0};
        qm_nxt = {qm[W-2:0], 1'b1};
      end
      default: begin
        q_nxt  = {q[W-2:0], 1'b1};
        qm_nxt = {q[W-2:0], 1'b0};
      end
    endcase
    r = in_adj ? qm_nxt : q_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (last) state_nxt = HOLD;
      HOLD:    if (out_ready && !last) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ACC;
      q       <= '0;
      qm      <= '1;
      cnt     <= '0;
      out_q   <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (last) begin
        q       <= '0;
        qm      <= '1;
        cnt     <= '0;
        out_q   <= r[N-1:0];
        out_ovf <= r[N] ^ r[N-1];
      end else if (acc) begin
        q   <= q_nxt;
        qm  <= qm_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_intdiv_otfconv.sv
// Bench for intdiv_otfconv: directed cases plus random streams against an integer-valued reference model.
module tb_intdiv_otfconv;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_digit = 2'b00;
  logic         in_adj = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_q;
  logic         out_ovf;

  intdiv_otfconv #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_adj(in_adj),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: integer value of the digits so far, and finished results awaiting drain
  int acc_val = 0;
  int acc_cnt = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] low_bits(input int r);
    logic [31:0] t;
    t = r;
    return t[N-1:0];
  endfunction

  function automatic logic is_ovf(input int r);
    return (r > (2 ** (N - 1)) - 1) || (r < -(2 ** (N - 1)));
  endfunction

  function automatic int dval(input logic [1:0] d);
    if (d == 2'b11) return -1;
    if (d == 2'b00) return 0;
    return 1;
  endfunction

  // one clock: drive at negedge, check, then let the edge happen
  task automatic cyc(input logic v, input logic [1:0] d, input logic a, input logic ordy);
    int r;
    @(negedge clk);
    in_valid  = v;
    in_digit  = d;
    in_adj    = a;
    out_ready = ordy;
    #1;
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("in_ready", in_ready, (exp_q.size() == 0) || ordy);
    if (out_valid && exp_q.size() != 0) begin
      chk("out_q", out_q, low_bits(exp_q[0]));
      chk("out_ovf", out_ovf, is_ovf(exp_q[0]));
    end
    if (out_valid && ordy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (v && in_ready) begin
      acc_val = 2 * acc_val + dval(d);
      acc_cnt++;
      if (acc_cnt == N) begin
        r = acc_val - (a ? 1 : 0);
        exp_q.push_back(r);
        acc_val = 0;
        acc_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    acc_val = 0;
    acc_cnt = 0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_q", out_q, '0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [1:0] d;
    int words;
    do_reset();

    // +1,0,-1,+1 (2'b10 as +1) -> 7
    cyc(1, 2'b01, 0, 0); cyc(1, 2'b00, 0, 0); cyc(1, 2'b11, 0, 0); cyc(1, 2'b10, 0, 0);
    cyc(0, 2'b00, 0, 0);
    chk("t1_q", out_q, 4'd7);
    chk("t1_ovf", out_ovf, 1'b0);
    cyc(0, 2'b00, 0, 1);

    // -1 x4 -> -15 -> 0001 with overflow
    for (int i = 0; i < 4; i++) cyc(1, 2'b11, 0, 1);
    cyc(0, 2'b00, 0, 0);
    chk("t2_q", out_q, 4'b0001);
    chk("t2_ovf", out_ovf, 1'b1);
    cyc(0, 2'b00, 0, 1);

    // 0,0,0,+1 with adj on the last beat -> 0
    cyc(1, 2'b00, 0, 1); cyc(1, 2'b00, 0, 1); cyc(1, 2'b00, 0, 1); cyc(1, 2'b01, 1, 1);
    cyc(0, 2'b00, 0, 0);
    chk("t3_q", out_q, 4'd0);
    cyc(0, 2'b00, 0, 1);
    // adj on beat 2 only is ignored -> 1
    cyc(1, 2'b00, 0, 1); cyc(1, 2'b00, 1, 1); cyc(1, 2'b00, 0, 1); cyc(1, 2'b01, 0, 1);
    cyc(0, 2'b00, 0, 0);
    chk("t3b_q", out_q, 4'd1);

    // backpressure: word held 5 cycles with digits pending, then overlap drain/accept
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2'b01, 0, 0);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    cyc(1, 2'b01, 0, 1);
    cyc(1, 2'b01, 0, 1); cyc(1, 2'b00, 0, 1); cyc(1, 2'b01, 0, 0);
    cyc(0, 2'b00, 0, 0);
    chk("bp_q", out_q, 4'd13);
    chk("bp_ovf", out_ovf, 1'b1);
    cyc(0, 2'b00, 0, 1);

    // reset mid-word discards partial digits
    cyc(1, 2'b11, 0, 1); cyc(1, 2'b11, 0, 1);
    do_reset();
    cyc(1, 2'b01, 0, 1); cyc(1, 2'b01, 0, 1); cyc(1, 2'b01, 0, 1); cyc(1, 2'b11, 0, 0);
    cyc(0, 2'b00, 0, 0);
    chk("rw_q", out_q, 4'b1101);
    chk("rw_ovf", out_ovf, 1'b1);
    // reset while a word is held
    do_reset();

    // random traffic
    words = 0;
    for (int c = 0; c < 3000; c++) begin
      d = 2'($urandom_range(0, 3));
      cyc(($urandom_range(0, 3) != 0), d, $urandom_range(0, 1) == 1, ($urandom_range(0, 2) != 0));
      if (c == 1500) do_reset();
    end
    for (int c = 0; c < 3; c++) cyc(0, 2'b00, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
